// File: rtl/ppu_pkg.sv
// Shared constants and helpers for the tile pixel-processing unit.
// Used by the fetch pipeline and its sync-delay line.
package ppu_pkg;

    localparam int PPU_LAT     = 3;
    localparam int COLOR_W     = 4;
    localparam int GLYPH_W     = 8;
    localparam int CODE_W      = 8;
    localparam int ATTR_FG_LSB = 8;
    localparam int ATTR_BG_LSB = 12;
    localparam int SYNC_W      = 3;

    // Glyph rows are stored MSB-first: pixel 0 is the leftmost, held in bit 7.
    function automatic logic glyph_bit(input logic [GLYPH_W-1:0] row, input logic [2:0] pix);
        return row[3'd7 - pix];
    endfunction

endpackage

// File: rtl/tile_ppu_fetch_if.sv
// Video-port read bus between the tile renderer and its charmap/chardata RAMs.
// Both RAMs return data one cycle after the registered address.
interface tile_ppu_fetch_if #(
    parameter int MAP_AW = 11,
    parameter int MAP_DW = 16,
    parameter int DAT_AW = 11
);

    logic [MAP_AW-1:0] charmap_addr;
    logic [MAP_DW-1:0] charmap_q;
    logic [DAT_AW-1:0] chardat_addr;
    logic [7:0]        chardat_q;

    modport master (
        output charmap_addr,
        output chardat_addr,
        input  charmap_q,
        input  chardat_q
    );

    modport slave (
        input  charmap_addr,
        input  chardat_addr,
        output charmap_q,
        output chardat_q
    );

endinterface

// File: rtl/sync_delay.sv
// Fixed-depth shift register that keeps sync/enable strobes aligned with
// the colour pipeline.
module sync_delay #(
    parameter int DEPTH = 3,
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] pipe_r [DEPTH];

    // Shift the strobes one stage per pixel clock.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                pipe_r[i] <= '0;
            end
        end else begin
            pipe_r[0] <= d;
            for (int i = 1; i < DEPTH; i++) begin
                pipe_r[i] <= pipe_r[i-1];
            end
        end
    end

    assign q = pipe_r[DEPTH-1];

endmodule

// File: rtl/tile_ppu_fetch.sv
// Pixel-rate tile renderer: screen coordinates -> scrolled map fetch -> glyph
// fetch -> 4-bit colour index, with per-tile attributes and a blinking cursor.
module tile_ppu_fetch
    import ppu_pkg::*;
#(
    parameter int               MAP_COLS_LOG2 = 6,
    parameter int               MAP_ROWS_LOG2 = 5,
    parameter int               CHAR_H_LOG2   = 3,
    parameter int               ATTR_EN       = 1,
    parameter logic [COLOR_W-1:0] DEF_FG      = 4'hF,
    parameter logic [COLOR_W-1:0] DEF_BG      = 4'h0,
    parameter int               BLINK_LOG2    = 4
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [9:0]                           x_in,
    input  logic [9:0]                           y_in,
    input  logic                                 de_in,
    input  logic                                 hs_in,
    input  logic                                 vs_in,
    input  logic [MAP_COLS_LOG2+2:0]             scroll_x,
    input  logic [MAP_ROWS_LOG2+CHAR_H_LOG2-1:0] scroll_y,
    input  logic                                 cur_en,
    input  logic [MAP_COLS_LOG2-1:0]             cur_col,
    input  logic [MAP_ROWS_LOG2-1:0]             cur_row,
    tile_ppu_fetch_if.master                     mem,
    output logic [COLOR_W-1:0]                   color,
    output logic                                 de_out,
    output logic                                 hs_out,
    output logic                                 vs_out
);

    localparam int SX_W   = MAP_COLS_LOG2 + 3;
    localparam int SY_W   = MAP_ROWS_LOG2 + CHAR_H_LOG2;
    localparam int MAP_AW = MAP_COLS_LOG2 + MAP_ROWS_LOG2;
    localparam int DAT_AW = CODE_W + CHAR_H_LOG2;

    logic [SX_W-1:0]         shadow_x_r;
    logic [SY_W-1:0]         shadow_y_r;
    logic                    vs_prev_r;
    logic [BLINK_LOG2:0]     frame_cnt_r;
    logic                    vs_rise_s;

    logic [SX_W-1:0]         sx_s;
    logic [SY_W-1:0]         sy_s;
    logic                    hit_s;

    logic [MAP_AW-1:0]       charmap_addr_r;
    logic [CHAR_H_LOG2-1:0]  line0_r;
    logic [2:0]              pix0_r;
    logic                    hit0_r;
    logic                    de0_r;

    logic [DAT_AW-1:0]       chardat_addr_r;
    logic [COLOR_W-1:0]      fg1_r;
    logic [COLOR_W-1:0]      bg1_r;
    logic [2:0]              pix1_r;
    logic                    hit1_r;
    logic                    de1_r;

    logic [COLOR_W-1:0]      fg_s;
    logic [COLOR_W-1:0]      bg_s;
    logic                    bit_s;
    logic                    inv_s;
    logic [COLOR_W-1:0]      color_r;
    logic [SYNC_W-1:0]       sync_q_s;
    logic                    unused_s;

    assign vs_rise_s = vs_in & ~vs_prev_r;

    // Frame-rate state: scroll shadows and blink counter move only at vsync rise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vs_prev_r   <= 1'b0;
            shadow_x_r  <= '0;
            shadow_y_r  <= '0;
            frame_cnt_r <= '0;
        end else begin
            vs_prev_r <= vs_in;
            if (vs_rise_s) begin
                shadow_x_r  <= scroll_x;
                shadow_y_r  <= scroll_y;
                frame_cnt_r <= frame_cnt_r + (BLINK_LOG2+1)'(1);
            end else begin
                shadow_x_r  <= shadow_x_r;
                shadow_y_r  <= shadow_y_r;
                frame_cnt_r <= frame_cnt_r;
            end
        end
    end

    // Scrolled map-space position; truncation gives wrap-around for free.
    always_comb begin
        sx_s  = x_in[SX_W-1:0] + shadow_x_r;
        sy_s  = y_in[SY_W-1:0] + shadow_y_r;
        hit_s = cur_en
              & (sx_s[SX_W-1:3] == cur_col)
              & (sy_s[SY_W-1:CHAR_H_LOG2] == cur_row);
    end

    // Stage 0: issue the tile-map read.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            charmap_addr_r <= '0;
            line0_r        <= '0;
            pix0_r         <= '0;
            hit0_r         <= 1'b0;
            de0_r          <= 1'b0;
        end else begin
            charmap_addr_r <= {sy_s[SY_W-1:CHAR_H_LOG2], sx_s[SX_W-1:3]};
            line0_r        <= sy_s[CHAR_H_LOG2-1:0];
            pix0_r         <= sx_s[2:0];
            hit0_r         <= hit_s;
            de0_r          <= de_in;
        end
    end

    generate
        if (ATTR_EN != 0) begin : g_attr
            assign fg_s = mem.charmap_q[ATTR_FG_LSB +: COLOR_W];
            assign bg_s = mem.charmap_q[ATTR_BG_LSB +: COLOR_W];
        end else begin : g_fixed
            assign fg_s = DEF_FG;
            assign bg_s = DEF_BG;
        end
    endgenerate

    // Stage 1: turn the tile code into a glyph-row read and latch its colours.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chardat_addr_r <= '0;
            fg1_r          <= '0;
            bg1_r          <= '0;
            pix1_r         <= '0;
            hit1_r         <= 1'b0;
            de1_r          <= 1'b0;
        end else begin
            chardat_addr_r <= {mem.charmap_q[CODE_W-1:0], line0_r};
            fg1_r          <= fg_s;
            bg1_r          <= bg_s;
            pix1_r         <= pix0_r;
            hit1_r         <= hit0_r;
            de1_r          <= de0_r;
        end
    end

    // Cursor inversion uses the live blink phase at pixel-output time.
    always_comb begin
        bit_s = glyph_bit(mem.chardat_q, pix1_r);
        inv_s = hit1_r & frame_cnt_r[BLINK_LOG2];
    end

    // Stage 2: pick foreground or background, blanked outside the active area.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            color_r <= '0;
        end else if (!de1_r) begin
            color_r <= '0;
        end else if (bit_s ^ inv_s) begin
            color_r <= fg1_r;
        end else begin
            color_r <= bg1_r;
        end
    end

    sync_delay #(
        .DEPTH (PPU_LAT),
        .WIDTH (SYNC_W)
    ) u_sync_delay (
        .clk (clk),
        .rst (rst),
        .d   ({hs_in, vs_in, de_in}),
        .q   (sync_q_s)
    );

    assign mem.charmap_addr = charmap_addr_r;
    assign mem.chardat_addr = chardat_addr_r;
    assign color            = color_r;
    assign hs_out           = sync_q_s[2];
    assign vs_out           = sync_q_s[1];
    assign de_out           = sync_q_s[0];

    assign unused_s = ^{x_in[9:SX_W], y_in[9:SY_W]};

endmodule

// File: doc/tile_ppu_fetch.md
Name: tile_ppu_fetch

Overview:
Parametrised successor of the fixed character PPU: a pixel-rate tile renderer that turns timing-generator coordinates into a 4-bit colour index. It reads a dual-port tile map (charmap) and glyph store (chardata) through their video ports. New over the fixed PPU:
- configurable map size and glyph height;
- per-tile foreground/background attributes;
- tear-free hardware scroll with wrap-around;
- blinking hardware cursor.
It sits between the VGA timing generator and the palette/DAC stage.

Parameters:
MAP_COLS_LOG2, 6, log2 of tile-map columns (64)
MAP_ROWS_LOG2, 5, log2 of tile-map rows (32)
CHAR_H_LOG2, 3, log2 of glyph height in lines (8); glyph width fixed at 8
ATTR_EN, 1, 1: charmap word is 16 bits {bg[3:0], fg[3:0], code[7:0]}; 0: code only, fixed colours used
DEF_FG, 4'hF, foreground index when ATTR_EN=0
DEF_BG, 4'h0, background index when ATTR_EN=0
BLINK_LOG2, 4, cursor toggles every 2^BLINK_LOG2 frames

Ports:
clk  in  1  pixel clock (clock_25 domain)
rst  in  1  asynchronous, active-high reset
x_in  in  10  current pixel column from timing generator
y_in  in  10  current pixel line
de_in  in  1  display enable
hs_in  in  1  hsync, active-high internal polarity
vs_in  in  1  vsync, active-high internal polarity
scroll_x  in  MAP_COLS_LOG2+3  requested horizontal pixel scroll
scroll_y  in  MAP_ROWS_LOG2+CHAR_H_LOG2  requested vertical pixel scroll
cur_en  in  1  cursor enable
cur_col  in  MAP_COLS_LOG2  cursor tile column (map space)
cur_row  in  MAP_ROWS_LOG2  cursor tile row (map space)
charmap_addr  out  MAP_COLS_LOG2+MAP_ROWS_LOG2  tile-map read address
charmap_q  in  ATTR_EN?16:8  tile-map data, 1-cycle synchronous read
chardat_addr  out  8+CHAR_H_LOG2  glyph read address
chardat_q  in  8  glyph row; bit 7 is the leftmost pixel
color  out  4  colour index
de_out  out  1  delayed display enable
hs_out  out  1  delayed hsync
vs_out  out  1  delayed vsync

Behaviour:
- Reset (async, rst=1): all outputs 0; scroll shadows 0; frame counter 0; pipeline registers 0. Normal operation resumes on the first clk edge after rst falls. A reset mid-frame is legal; output is invalid until 3 cycles later.
- Scroll shadows: on a vs_in rising edge (vs_in=1, previous=0), latch scroll_x/scroll_y into shadows. Mid-frame changes have no effect until the next frame.
- Frame counter: BLINK_LOG2+1 bits, increments on each vs_in rising edge and wraps. blink = counter MSB.
- Stage 0 (edge k):
  - sx = x_in[MAP_COLS_LOG2+2:0] + shadow_x, truncated (wraps modulo map width in pixels).
  - sy = y_in[MAP_ROWS_LOG2+CHAR_H_LOG2-1:0] + shadow_y, truncated.
  - Register charmap_addr = {sy tile-row bits, sx[MAP_COLS_LOG2+2:3]}.
  - Carry forward: line = sy[CHAR_H_LOG2-1:0], pix = sx[2:0], hit = cur_en & (tile col==cur_col) & (tile row==cur_row).
- Stage 1 (edge k+1): register chardat_addr = {charmap_q[7:0], line}. Register fg/bg from charmap_q[11:8]/[15:12], or DEF_FG/DEF_BG when ATTR_EN=0. Carry pix and hit.
- Stage 2 (edge k+2):
  - bit = chardat_q[7-pix]; inv = hit & blink.
  - color = (bit^inv) ? fg : bg when the delayed de is 1; otherwise color = 0.
- Latency: exactly 3 cycles from x_in/y_in/de_in to color. hs/vs/de_out are delayed by exactly 3 cycles, keeping them aligned with color.
- Addresses are driven every cycle, including blanking; no read enable is used.
- A vs rising edge in the same cycle as active pixels (malformed timing) still latches the shadows. Pixels already in the pipeline keep their old scroll values.

Decomposition:
- Package ppu_pkg: PPU_LAT=3, COLOR_W=4, GLYPH_W=8, CODE_W=8, attribute field offsets.
- One sub-module, sync_delay (parameter DEPTH, WIDTH, async reset): delays {hs,vs,de} by PPU_LAT.

Test Plan:
- Reset mid-line: assert rst for 2 cycles → color, de_out, hs_out, vs_out and both addresses are 0 during reset. Valid output appears 3 cycles after release.
- Basic fetch: map[0]=16'h1F41, glyph 'A' line 0=8'h18, x=3,y=0,de=1 → charmap_addr=0, chardat_addr=0x208. Three cycles later color=4'hF (fg). At x=0, color=4'h1 (bg).
- Horizontal wrap: scroll_x latched to 510 at a vs edge; x=4 → sx=2, tile column 0 (wraps, not column 63).
- Tear-free scroll: change scroll_y mid-frame → charmap_addr unchanged until after the next vs rising edge.
- Cursor blink: cur_en=1 at tile (2,1), BLINK_LOG2=1 → tile colours invert for 2 frames, then normal for 2 frames, repeating. Other tiles are unaffected.
- ATTR_EN=0 build: set glyph bit → color=DEF_FG; clear bit → DEF_BG. de_in=0 → color=0.
